regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised, multi-port successor to the 32x32 integer register file.
- Configurable width, depth, number of read ports and number of write ports.
- Optional hardwired-zero entry 0 and optional same-cycle write-to-read bypass.
- Built-in clear sequencer zeroes every entry after reset or on request, with a ready flag; the decode/issue stage stalls on `ready`.

Parameters:
- `DATA_W`, 32, bits per register.
- `DEPTH`, 32, number of registers (power of two, >= 2).
- `ADDR_W`, $clog2(DEPTH), address width (derived, not overridden).
- `NUM_RD`, 2, number of read ports.
- `NUM_WR`, 1, number of write ports (1..4).
- `ZERO_REG0`, 1, 1 = entry 0 reads as 0 and ignores writes.
- `BYPASS`, 1, 1 = a read of an address written in the same cycle returns the incoming write data.

Ports:
- `clk` input 1 system clock, rising edge.
- `rst` input 1 synchronous, active-high reset.
- `clr` input 1 request a full clear (sampled only when `ready`=1).
- `ready` output 1 high when the file accepts writes and reads are valid.
- `wr_en` input NUM_WR per-port write enable.
- `wr_addr` input NUM_WR*ADDR_W packed write addresses; port p = bits [p*ADDR_W +: ADDR_W].
- `wr_data` input NUM_WR*DATA_W packed write data.
- `rd_addr` input NUM_RD*ADDR_W packed read addresses.
- `rd_data` output NUM_RD*DATA_W packed read data (combinational).

Behaviour:
- Reset (`rst`=1 at a rising edge): state=CLEAR, clear index=0, `ready`=0. Array contents are not touched by reset itself. `rd_data` is all zeros while `ready`=0.
- States: CLEAR, RUN.
- CLEAR:
  - Each edge with `rst`=0 writes 0 to entry[idx], then idx+=1.
  - On the edge where idx==DEPTH-1: go to RUN, `ready`=1 from the next cycle.
  - `ready` therefore rises exactly DEPTH edges after `rst` deasserts (32 for defaults).
- RUN:
  - `clr`=1 at an edge: go to CLEAR, idx=0, `ready`=0 next cycle.
  - Writes in the `clr` cycle are still performed; they are overwritten later by the clear.
- Writes:
  - Only when state=RUN and `rst`=0.
  - `wr_en`[p]=1 stores `wr_data`[p] into entry[`wr_addr`[p]] at the rising edge.
  - Writes with `wr_en`=0 in CLEAR, or any write attempted during CLEAR, are discarded silently.
- Write-write conflict: if several enabled ports target the same address in one cycle, the highest-numbered port wins.
- `ZERO_REG0`=1:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0 even with bypass enabled.
- Reads (RUN):
  - Combinational: `rd_data`[r] = entry[`rd_addr`[r]].
  - If `BYPASS`=1 and an enabled write port targets the same address in that cycle, return that port's `wr_data`. Highest-numbered matching port wins.
  - If `BYPASS`=0, return the old value until the next cycle.
- Read addresses need no range check: DEPTH is a power of two, so every address is in range.
- Reset mid-clear restarts from idx=0. Reset mid-RUN enters CLEAR.
- `rst` and `clr` both high: `rst` takes priority (same outcome).
- No X on `rd_data` after the first clear completes.

Decomposition:
- Package `regfile_pkg`:
  - state enum {CLEAR, RUN}
  - default constants `RF_DATA_W`=32, `RF_DEPTH`=32
  - helper function for per-port slice extraction
- Sub-module `regfile_clear_fsm` (parameter DEPTH):
  - Owns state, idx and `ready`.
  - Outputs `clr_we`, `clr_addr`.
  - The array/port logic stays in `regfile_mp`.

Test Plan:
- Hold `rst` 2 cycles, release -> `ready`=0 for exactly 32 edges, then 1. Reading any address then -> 0x00000000.
- After ready: write port0 addr 1 = 0xA5A5A5A5 -> next cycle `rd_addr`0=1 reads 0xA5A5A5A5. Same-cycle read of addr 1 during a write of 0x12345678 with `BYPASS`=1 -> 0x12345678.
- `NUM_WR`=2: both ports write addr 5 with 0x11111111 (p0) and 0x22222222 (p1) -> entry 5 reads 0x22222222.
- Write 0xFFFFFFFF to addr 0 with `ZERO_REG0`=1 -> addr 0 reads 0, including the same-cycle bypass read.
- Fill addrs 1..3, pulse `clr` -> `ready` low for 32 cycles. Writes issued during that window are dropped. Afterwards addrs 1..3 read 0.
- Assert `rst` at idx=10 of a clear -> the clear restarts, and `ready` rises 32 edges after `rst` is released.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
//   state_t   : clear-sequencer states
//   RF_*      : default geometry
//   slice_lo  : low bit index of port p inside a packed per-port bus
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;

  // Packed buses carry port p in bits [p*width +: width].
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: after reset or a clr request, zeroes entries 0..DEPTH-1
// one per cycle, then raises ready.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clr          : clear request, honoured only while ready
//   ready        : high in RUN
//   clr_we       : zero-write strobe for entry clr_addr
//   clr_addr     : entry being cleared this cycle
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter  int DEPTH  = RF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    ready       = 1'b0;
    clr_we      = 1'b0;
    clr_addr    = r_idx;
    case (r_state)
      CLEAR: begin
        clr_we    = 1'b1;
        w_idx_nxt = r_idx + 1'b1;
        // Last entry written this edge; index wraps back to 0 for next time.
        if (r_idx == ADDR_W'(DEPTH - 1)) w_state_nxt = RUN;
      end
      RUN: begin
        ready = 1'b1;
        if (clr) begin
          w_state_nxt = CLEAR;
          w_idx_nxt   = '0;
        end
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with built-in clear sequencer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : request full clear (only while ready)
//   ready     : writes accepted / reads valid
//   wr_en     : [NUM_WR] write enables
//   wr_addr   : [NUM_WR*ADDR_W] packed write addresses
//   wr_data   : [NUM_WR*DATA_W] packed write data
//   rd_addr   : [NUM_RD*ADDR_W] packed read addresses
//   rd_data   : [NUM_RD*DATA_W] packed combinational read data
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W    = RF_DATA_W,
  parameter  int DEPTH     = RF_DEPTH,
  parameter  int NUM_RD    = 2,
  parameter  int NUM_WR    = 1,
  parameter  int ZERO_REG0 = 1,
  parameter  int BYPASS    = 1,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  output logic                     ready,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_ready;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;

  regfile_clear_fsm #(.DEPTH(DEPTH)) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .ready    (w_ready),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign ready = w_ready;

  // Array update. Later loop iterations override earlier ones, so the
  // highest-numbered port wins a same-address conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_we) begin
        r_mem[w_clr_addr] <= '0;
      end else if (w_ready) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_en[p] &&
              !(ZERO_REG0 != 0 && wr_addr[slice_lo(p, ADDR_W) +: ADDR_W] == '0))
            r_mem[wr_addr[slice_lo(p, ADDR_W) +: ADDR_W]] <=
              wr_data[slice_lo(p, DATA_W) +: DATA_W];
        end
      end
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_val;

    assign w_ra = rd_addr[slice_lo(r, ADDR_W) +: ADDR_W];

    always_comb begin
      w_val = '0;
      // Zero-register check comes first so it also masks the bypass path.
      if (w_ready && !(ZERO_REG0 != 0 && w_ra == '0)) begin
        w_val = r_mem[w_ra];
        if (BYPASS != 0) begin
          for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && wr_addr[slice_lo(p, ADDR_W) +: ADDR_W] == w_ra)
              w_val = wr_data[slice_lo(p, DATA_W) +: DATA_W];
          end
        end
      end
    end

    assign rd_data[slice_lo(r, DATA_W) +: DATA_W] = w_val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (2 read ports, 2 write ports, zero reg, bypass).
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          ready;
  logic [1:0]    wr_en = '0;
  logic [2*AW-1:0] wr_addr = '0;
  logic [2*DW-1:0] wr_data = '0;
  logic [2*AW-1:0] rd_addr = '0;
  logic [2*DW-1:0] rd_data;

  int checks = 0;
  int failures = 0;

  regfile_mp #(
    .DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG0(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .ready(ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  // Count edges until ready rises (bounded); returns 999 on timeout.
  task automatic wait_ready(output int n);
    n = 999;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (ready) begin
        n = i;
        break;
      end
    end
  endtask

  int n;

  initial begin
    // Reset for two cycles.
    step();
    step();
    chk("reset_ready", 64'(ready), 64'd0);
    rd(5'd1, 5'd7);
    chk("reset_rd", 64'(rd_data), 64'd0);
    rst = 1'b0;
    wait_ready(n);
    chk("init_clear_edges", 64'(n), 64'd32);

    rd(5'd1, 5'd31);
    chk("post_clear_rd", 64'(rd_data), 64'd0);

    // Single write, read next cycle.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd1}; wr_data = {32'h0, 32'hA5A5A5A5};
    step();
    wr_en = 2'b00;
    rd(5'd1, 5'd2);
    chk("wr_rd_a1", 64'(rd_data), {32'h0, 32'hA5A5A5A5});

    // Same-cycle bypass on both read ports.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd1}; wr_data = {32'h0, 32'h12345678};
    rd(5'd1, 5'd1);
    chk("bypass_a1", 64'(rd_data), {32'h12345678, 32'h12345678});
    step();
    wr_en = 2'b00;
    rd(5'd1, 5'd0);
    chk("after_bypass_a1", 64'(rd_data), {32'h0, 32'h12345678});

    // Write-write conflict: port 1 wins, both in bypass and in the array.
    wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {32'h22222222, 32'h11111111};
    rd(5'd5, 5'd1);
    chk("conflict_bypass", 64'(rd_data), {32'h12345678, 32'h22222222});
    step();
    wr_en = 2'b00;
    rd(5'd5, 5'd5);
    chk("conflict_stored", 64'(rd_data), {32'h22222222, 32'h22222222});

    // Hardwired zero entry, including the bypass path.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFFFFFFFF};
    rd(5'd0, 5'd5);
    chk("zero_bypass", 64'(rd_data), {32'h22222222, 32'h0});
    step();
    wr_en = 2'b00;
    rd(5'd0, 5'd0);
    chk("zero_stored", 64'(rd_data), 64'd0);

    // Fill 1..3, then clear.
    wr_en = 2'b11; wr_addr = {5'd2, 5'd1}; wr_data = {32'h00000002, 32'h00000001};
    step();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h00000003};
    step();
    wr_en = 2'b00;
    rd(5'd3, 5'd2);
    chk("fill_rd", 64'(rd_data), {32'h00000002, 32'h00000003});
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ready_low", 64'(ready), 64'd0);
    rd(5'd1, 5'd3);
    chk("clr_rd_zero", 64'(rd_data), 64'd0);
    // Writes attempted throughout the clear window must be dropped.
    wr_en = 2'b11; wr_addr = {5'd3, 5'd2}; wr_data = {32'hBEEFBEEF, 32'hDEADDEAD};
    n = 999;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (ready) begin
        n = i;
        wr_en = 2'b00;
        break;
      end
    end
    wr_en = 2'b00;
    chk("clr_edges", 64'(n), 64'd32);
    rd(5'd1, 5'd2);
    chk("clr_a1_a2", 64'(rd_data), 64'd0);
    rd(5'd3, 5'd5);
    chk("clr_a3_a5", 64'(rd_data), 64'd0);

    // Reset in the middle of a clear restarts it.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h00000044};
    step();
    wr_en = 2'b00;
    rd(5'd4, 5'd0);
    chk("pre_rst_a4", 64'(rd_data), {32'h0, 32'h00000044});
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) step();   // clear index is now 10
    chk("mid_clear_ready", 64'(ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready(n);
    chk("rst_mid_clear_edges", 64'(n), 64'd32);
    rd(5'd4, 5'd9);
    chk("rst_mid_clear_a4", 64'(rd_data), 64'd0);

    // Reset in RUN with clr also high: reset dominates, same clear outcome.
    rst = 1'b1; clr = 1'b1;
    step();
    rst = 1'b0; clr = 1'b0;
    chk("rst_run_ready", 64'(ready), 64'd0);
    wait_ready(n);
    chk("rst_run_edges", 64'(n), 64'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
